// File: rtl/path_command_gen.sv
// path_command_gen: walks a tracked position to a requested (x,y) target, X axis first,
// issuing {dir, steps} commands of at most MAX_STEP units over a valid/ready port.
module path_command_gen #(
  parameter int COORD_W  = 5,
  parameter int STEP_W   = 2,
  parameter int MAX_STEP = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic [COORD_W-1:0] tgt_x,
  input  logic [COORD_W-1:0] tgt_y,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_dir,
  output logic [STEP_W-1:0]  cmd_steps,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, DONE} state_t;
  localparam logic [COORD_W:0]  MAX_D = (COORD_W+1)'(MAX_STEP);
  localparam logic [STEP_W-1:0] MAX_S = STEP_W'(MAX_STEP);
  state_t             r_state;
  logic [COORD_W-1:0] r_tx, r_ty, r_cx, r_cy;
  logic               w_px, w_py, w_xlast, w_ylast;
  logic [COORD_W:0]   w_adx, w_ady;
  logic [STEP_W-1:0]  w_sx, w_sy;
  // distances are one bit wider than coordinates so the subtraction never wraps
  assign w_px    = r_tx > r_cx;
  assign w_py    = r_ty > r_cy;
  assign w_adx   = w_px ? {1'b0, r_tx} - {1'b0, r_cx} : {1'b0, r_cx} - {1'b0, r_tx};
  assign w_ady   = w_py ? {1'b0, r_ty} - {1'b0, r_cy} : {1'b0, r_cy} - {1'b0, r_ty};
  assign w_sx    = w_adx > MAX_D ? MAX_S : w_adx[STEP_W-1:0];
  assign w_sy    = w_ady > MAX_D ? MAX_S : w_ady[STEP_W-1:0];
  assign w_xlast = w_adx <= MAX_D;
  assign w_ylast = w_ady <= MAX_D;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_tx    <= '0;
      r_ty    <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
    end else begin
      case (r_state)
        IDLE: if (tgt_valid) begin
          r_tx    <= tgt_x;
          r_ty    <= tgt_y;
          r_state <= tgt_x != r_cx ? MOVE_X : tgt_y != r_cy ? MOVE_Y : DONE;
        end
        MOVE_X: if (cmd_ready) begin
          r_cx <= w_px ? r_cx + COORD_W'(w_sx) : r_cx - COORD_W'(w_sx);
          if (w_xlast) r_state <= r_ty != r_cy ? MOVE_Y : DONE;
        end
        MOVE_Y: if (cmd_ready) begin
          r_cy <= w_py ? r_cy + COORD_W'(w_sy) : r_cy - COORD_W'(w_sy);
          if (w_ylast) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // dir bit 1 = negative direction, bit 0 = y axis
  assign tgt_ready = r_state == IDLE;
  assign cmd_valid = r_state == MOVE_X || r_state == MOVE_Y;
  assign cmd_dir   = r_state == MOVE_X ? {~w_px, 1'b0} : r_state == MOVE_Y ? {~w_py, 1'b1} : 2'd0;
  assign cmd_steps = r_state == MOVE_X ? w_sx : r_state == MOVE_Y ? w_sy : '0;
  assign done      = r_state == DONE;
  assign cur_x     = r_cx;
  assign cur_y     = r_cy;
endmodule

// File: tb/tb_path_command_gen.sv
// tb_path_command_gen: directed + random stimulus against a move-list reference model.
module tb_path_command_gen;
  logic       clk = 0, reset, tgt_valid, cmd_ready;
  logic [4:0] tgt_x, tgt_y, cur_x, cur_y;
  logic       tgt_ready, cmd_valid, done;
  logic [1:0] cmd_dir, cmd_steps;
  int checks = 0, errors = 0, fires = 0;
  int m_cx = 0, m_cy = 0;
  logic [3:0] m_q[$];
  bit m_done = 0;

  path_command_gen dut (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_x(tgt_x), .tgt_y(tgt_y), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cur_x(cur_x), .cur_y(cur_y), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // the whole move list for a target, as {dir, steps}, built by plain arithmetic
  function automatic void plan(input int tx, input int ty);
    int d, s;
    d = tx - m_cx;
    while (d != 0) begin
      s = (d > 0 ? d : -d) > 3 ? 3 : (d > 0 ? d : -d);
      m_q.push_back({d > 0 ? 2'd0 : 2'd2, 2'(s)});
      d = d > 0 ? d - s : d + s;
    end
    d = ty - m_cy;
    while (d != 0) begin
      s = (d > 0 ? d : -d) > 3 ? 3 : (d > 0 ? d : -d);
      m_q.push_back({d > 0 ? 2'd1 : 2'd3, 2'(s)});
      d = d > 0 ? d - s : d + s;
    end
  endfunction

  task automatic cyc(input bit rst, input bit tv, input int tx, input int ty, input bit cr);
    bit busy;
    int s;
    reset = rst; tgt_valid = tv; tgt_x = 5'(tx); tgt_y = 5'(ty); cmd_ready = cr;
    busy = m_q.size() != 0;
    chk("cmd_valid", int'(cmd_valid), int'(busy));
    chk("cmd_dir", int'(cmd_dir), busy ? int'(m_q[0][3:2]) : 0);
    chk("cmd_steps", int'(cmd_steps), busy ? int'(m_q[0][1:0]) : 0);
    chk("done", int'(done), int'(m_done));
    chk("tgt_ready", int'(tgt_ready), int'(!busy && !m_done));
    chk("cur_x", int'(cur_x), m_cx);
    chk("cur_y", int'(cur_y), m_cy);
    if (cmd_valid && cmd_ready) fires++;
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_done = 0; m_cx = 0; m_cy = 0;
    end else if (m_done) m_done = 0;
    else if (busy) begin
      if (cr) begin
        s = int'(m_q[0][1:0]);
        case (m_q[0][3:2])
          2'd0: m_cx += s;
          2'd1: m_cy += s;
          2'd2: m_cx -= s;
          default: m_cy -= s;
        endcase
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1;
      end
    end else if (tv) begin
      plan(tx, ty);
      if (m_q.size() == 0) m_done = 1;
    end
    #1;
  endtask

  initial begin
    reset = 1; tgt_valid = 0; tgt_x = 0; tgt_y = 0; cmd_ready = 1;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    // (5,0) with free-running consumer
    cyc(0, 1, 5, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 1);
    // (5,7) with a 3-cycle stall on the first command
    cyc(0, 1, 5, 7, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 1);
    // (2,1) then the same target again
    cyc(0, 1, 2, 1, 1);
    repeat (5) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 2, 1, 1);
    repeat (2) cyc(0, 0, 0, 0, 1);
    chk("same_tgt_pos", int'({cur_x, cur_y}), (2 << 5) | 1);
    // full diagonal sweep
    cyc(1, 0, 0, 0, 1);
    fires = 0;
    cyc(0, 1, 31, 31, 1);
    repeat (25) cyc(0, 0, 0, 0, 1);
    chk("sweep_fires", fires, 22);
    chk("sweep_pos", int'({cur_x, cur_y}), 1023);
    // reset mid-MOVE_Y, with ignored targets while busy
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, 4, 20, 1);
    repeat (3) cyc(0, 1, 9, 9, 1);
    cyc(1, 1, 9, 9, 1);
    cyc(0, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int tx, ty;
      tx = $urandom_range(0, 3) == 0 ? m_cx : $urandom_range(0, 31);
      ty = $urandom_range(0, 3) == 0 ? m_cy : ($urandom_range(0, 5) == 0 ? 31 : $urandom_range(0, 31));
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, tx, ty, $urandom_range(0, 3) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
